// File: rtl/ram_sp_sched.sv
// Sequencer for a single-port, enable-gated RAM: fills 0..len-1 from a write stream,
// then streams 0..len-1 for (reps+1) passes to a ready/valid sink, freezing en on backpressure.
module ram_sp_sched #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 8,
    parameter int LATENCY    = 3,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_W      = ADDR_WIDTH + 1,
    parameter int REPS_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [REPS_W-1:0]     cfg_reps,
    output logic                  busy,
    output logic                  done,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_di,
    input  logic [WIDTH-1:0]      ram_dout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [REPS_W-1:0]     pass_r;
    logic [LEN_W-1:0]      len_r;
    logic [REPS_W-1:0]     reps_r;
    logic [LATENCY-1:0]    vld_pipe_r;
    logic                  done_r;

    logic [LEN_W-1:0]      len_sel_s;
    logic [LEN_W-1:0]      last_idx_s;
    logic                  start_ok_s;
    logic                  wr_fire_s;
    logic                  wr_last_s;
    logic                  issue_s;
    logic                  rd_phase_s;
    logic                  adv_s;
    logic                  rd_fire_s;
    logic                  rd_last_s;
    logic                  final_issue_s;
    logic [LATENCY:0]      vld_ext_s;
    logic [LATENCY-1:0]    vld_nxt_s;
    logic                  drain_done_s;

    // Out-of-range lengths are clamped so the pointers can never run past the RAM.
    assign len_sel_s     = (cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;
    assign last_idx_s    = len_r - LEN_W'(1);
    assign start_ok_s    = (state_r == ST_IDLE) && start && (cfg_len != {LEN_W{1'b0}});

    assign wr_fire_s     = (state_r == ST_WRITE) && s_valid;
    assign wr_last_s     = ({1'b0, wr_ptr_r} == last_idx_s);

    assign issue_s       = (state_r == ST_READ);
    assign rd_phase_s    = (state_r == ST_READ) || (state_r == ST_DRAIN);
    assign adv_s         = !(m_valid && !m_ready);
    assign rd_fire_s     = issue_s && adv_s;
    assign rd_last_s     = ({1'b0, rd_ptr_r} == last_idx_s);
    assign final_issue_s = rd_fire_s && rd_last_s && (pass_r == reps_r);

    // The valid tags advance in lock-step with the en-gated RAM read pipeline.
    assign vld_ext_s     = {vld_pipe_r, issue_s};
    assign vld_nxt_s     = adv_s ? vld_ext_s[LATENCY-1:0] : vld_pipe_r;
    assign drain_done_s  = (state_r == ST_DRAIN) && (vld_nxt_s == {LATENCY{1'b0}});

    // Phase sequencing
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_nxt_s = ST_WRITE;
                else            state_nxt_s = ST_IDLE;
            end
            ST_WRITE: begin
                if (wr_fire_s && wr_last_s) state_nxt_s = ST_READ;
                else                        state_nxt_s = ST_WRITE;
            end
            ST_READ: begin
                if (final_issue_s) state_nxt_s = ST_DRAIN;
                else               state_nxt_s = ST_READ;
            end
            ST_DRAIN: begin
                if (drain_done_s) state_nxt_s = ST_IDLE;
                else              state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // RAM port drive: write strobes follow the input handshake, reads follow the sink.
    always_comb begin
        s_ready  = 1'b0;
        ram_we   = 1'b0;
        ram_en   = 1'b0;
        ram_addr = {ADDR_WIDTH{1'b0}};
        case (state_r)
            ST_WRITE: begin
                s_ready  = 1'b1;
                ram_we   = wr_fire_s;
                ram_en   = wr_fire_s;
                ram_addr = wr_ptr_r;
            end
            ST_READ: begin
                ram_en   = adv_s;
                ram_addr = rd_ptr_r;
            end
            ST_DRAIN: begin
                ram_en   = adv_s;
                ram_addr = {ADDR_WIDTH{1'b0}};
            end
            default: begin
                ram_en   = 1'b0;
                ram_addr = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    assign busy    = (state_r != ST_IDLE);
    assign done    = done_r;
    assign m_valid = vld_pipe_r[LATENCY-1];
    assign m_data  = ram_dout;
    assign ram_di  = s_data;

    // State, pointers, configuration and valid pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
            pass_r     <= {REPS_W{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            reps_r     <= {REPS_W{1'b0}};
            vld_pipe_r <= {LATENCY{1'b0}};
            done_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= drain_done_s;

            if (start_ok_s) begin
                len_r    <= len_sel_s;
                reps_r   <= cfg_reps;
                wr_ptr_r <= {ADDR_WIDTH{1'b0}};
                rd_ptr_r <= {ADDR_WIDTH{1'b0}};
                pass_r   <= {REPS_W{1'b0}};
            end else begin
                if (wr_fire_s) begin
                    if (wr_last_s) wr_ptr_r <= {ADDR_WIDTH{1'b0}};
                    else           wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
                end
                if (rd_fire_s) begin
                    if (rd_last_s) begin
                        rd_ptr_r <= {ADDR_WIDTH{1'b0}};
                        pass_r   <= pass_r + REPS_W'(1);
                    end else begin
                        rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
                    end
                end
            end

            if (rd_phase_s) vld_pipe_r <= vld_nxt_s;
            else            vld_pipe_r <= {LATENCY{1'b0}};
        end
    end

endmodule

// File: tb/tb_ram_sp_sched.sv
// Self-checking bench for ram_sp_sched: behavioural RAM plus a queue-based model of the
// expected read stream (len words per pass, reps+1 passes, addresses 0..len-1).
module tb_ram_sp_sched;

    localparam int DEPTH      = 8;
    localparam int WIDTH      = 8;
    localparam int LATENCY    = 3;
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int LEN_W      = ADDR_WIDTH + 1;
    localparam int REPS_W     = 8;

    logic                  clk      = 1'b0;
    logic                  rst      = 1'b1;
    logic                  start    = 1'b0;
    logic [LEN_W-1:0]      cfg_len  = '0;
    logic [REPS_W-1:0]     cfg_reps = '0;
    logic                  busy;
    logic                  done;
    logic                  s_valid  = 1'b0;
    logic                  s_ready;
    logic [WIDTH-1:0]      s_data   = '0;
    logic                  m_valid;
    logic                  m_ready  = 1'b1;
    logic [WIDTH-1:0]      m_data;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WIDTH-1:0]      ram_di;
    logic [WIDTH-1:0]      ram_dout;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] wdata  [DEPTH];
    logic [WIDTH-1:0] tb_mem [DEPTH];
    logic [WIDTH-1:0] rpipe  [LATENCY];

    ram_sp_sched #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .LATENCY(LATENCY),
        .ADDR_WIDTH(ADDR_WIDTH), .LEN_W(LEN_W), .REPS_W(REPS_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_reps(cfg_reps),
        .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Write-first single-port RAM whose read pipeline only moves when en=1.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                tb_mem[ram_addr] <= ram_di;
                rpipe[0]         <= ram_di;
            end else begin
                rpipe[0] <= tb_mem[ram_addr];
            end
            for (int i = 1; i < LATENCY; i++) rpipe[i] <= rpipe[i-1];
        end
    end
    assign ram_dout = rpipe[LATENCY-1];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Full job: start, write len words, read len*(reps+1) words checked against the model.
    task automatic run_job(input int len, input int reps, input int wmode, input int rmode,
                           input bit busy_start, input string tag);
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] exp_word;
        logic [WIDTH-1:0] prev_data;
        int total, wr_i, wcyc, k, got, issued, first_idx, last_idx, stall;
        bit stall_used, prev_stall;
        total = len * (reps + 1);
        for (int p = 0; p <= reps; p++)
            for (int a = 0; a < len; a++) exp_q.push_back(wdata[a]);

        start = 1'b1; cfg_len = LEN_W'(len); cfg_reps = REPS_W'(reps);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s idle_before_start: busy=%b want 0", tag, busy); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL %s start_accept: busy=%b s_ready=%b done=%b want 1 1 0", tag, busy, s_ready, done);
        end

        wr_i = 0; wcyc = 0;
        while (wr_i < len && wcyc < 20 * len + 20) begin
            case (wmode)
                0:       s_valid = 1'b1;
                1:       s_valid = (wcyc % 3 == 2);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = wdata[wr_i];
            if (busy_start && wcyc == 1) begin start = 1'b1; cfg_len = LEN_W'(1); cfg_reps = '0; end
            else start = 1'b0;
            #1;
            checks++;
            if (ram_we !== s_valid || ram_en !== s_valid) begin
                errors++; $display("FAIL %s wr_strobe: we=%b en=%b want %b", tag, ram_we, ram_en, s_valid);
            end
            if (s_valid) begin
                checks++;
                if (ram_addr !== ADDR_WIDTH'(wr_i)) begin
                    errors++; $display("FAIL %s wr_addr: got %0d want %0d", tag, ram_addr, wr_i);
                end
                wr_i++;
            end
            @(posedge clk); #1;
            wcyc++;
        end
        start = 1'b0;
        checks++;
        if (wr_i != len) begin errors++; $display("FAIL %s wr_timeout: wrote %0d want %0d", tag, wr_i, len); end

        got = 0; issued = 0; k = 0; first_idx = -1; last_idx = -1; stall = 0;
        stall_used = 1'b0; prev_stall = 1'b0; prev_data = '0;
        while (got < total && k < 8 * total + 40) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = WIDTH'($urandom);
            m_ready = 1'b1;
            if (rmode == 1) m_ready = ($urandom_range(0, 3) != 0);
            else if (rmode == 2) begin
                if (!stall_used && got == 2 && m_valid === 1'b1) begin stall = 5; stall_used = 1'b1; end
                if (stall > 0) begin m_ready = 1'b0; stall--; end
            end
            #1;
            checks++;
            if (s_ready !== 1'b0 || ram_we !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL %s rd_ctl: s_ready=%b we=%b done=%b busy=%b want 0 0 0 1", tag, s_ready, ram_we, done, busy);
            end
            if (k == 0) begin
                checks++;
                if (ram_en !== 1'b1 || ram_addr !== '0) begin
                    errors++; $display("FAIL %s first_issue: en=%b addr=%0d want 1 0", tag, ram_en, ram_addr);
                end
            end
            if (issued < total && ram_en === 1'b1) begin
                checks++;
                if (ram_addr !== ADDR_WIDTH'(issued % len)) begin
                    errors++; $display("FAIL %s rd_addr: got %0d want %0d", tag, ram_addr, issued % len);
                end
                issued++;
            end
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    errors++; $display("FAIL %s hold: m_valid=%b m_data=%h want 1 %h", tag, m_valid, m_data, prev_data);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b0) begin
                checks++;
                if (ram_en !== 1'b0) begin errors++; $display("FAIL %s freeze: ram_en=%b want 0", tag, ram_en); end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL %s extra_word: got %h want none", tag, m_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (m_data !== exp_word) begin
                        errors++; $display("FAIL %s data: got %h want %h (word %0d)", tag, m_data, exp_word, got);
                    end
                end
                if (first_idx < 0) first_idx = k;
                last_idx = k;
                got++;
            end
            prev_stall = (m_valid === 1'b1 && m_ready === 1'b0);
            prev_data  = m_data;
            @(posedge clk); #1;
            k++;
        end
        #1;
        checks++;
        if (got != total || issued != total) begin
            errors++; $display("FAIL %s rd_count: got %0d issued %0d want %0d", tag, got, issued, total);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL %s done_pulse: done=%b busy=%b m_valid=%b want 1 0 0", tag, done, busy, m_valid);
        end
        if (rmode == 0) begin
            checks++;
            if (first_idx != LATENCY || last_idx != LATENCY + total - 1) begin
                errors++; $display("FAIL %s latency: first=%0d last=%0d want %0d %0d", tag, first_idx, last_idx, LATENCY, LATENCY + total - 1);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, s_ready, m_valid, ram_en, ram_we} !== 6'b0 || ram_addr !== '0) begin
            errors++; $display("FAIL reset_state: flags=%b addr=%0d want 000000 0", {busy, done, s_ready, m_valid, ram_en, ram_we}, ram_addr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ram_en !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: busy=%b done=%b en=%b want 0 0 0", busy, done, ram_en);
        end
    endtask

    task automatic test_basic;
        for (int i = 0; i < DEPTH; i++) wdata[i] = WIDTH'(8'h0A + i);
        run_job(4, 0, 0, 0, 1'b0, "basic");
    endtask

    task automatic test_reps;
        for (int i = 0; i < DEPTH; i++) wdata[i] = WIDTH'($urandom);
        run_job(3, 2, 0, 0, 1'b0, "reps");
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < DEPTH; i++) wdata[i] = WIDTH'($urandom);
        run_job(5, 1, 0, 2, 1'b0, "stall5");
        for (int i = 0; i < DEPTH; i++) wdata[i] = WIDTH'($urandom);
        run_job(6, 2, 2, 1, 1'b0, "rand_bp");
    endtask

    task automatic test_gapped_write;
        for (int i = 0; i < DEPTH; i++) wdata[i] = WIDTH'($urandom);
        run_job(4, 0, 1, 0, 1'b0, "gapped");
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        start = 1'b1; cfg_len = LEN_W'(4); cfg_reps = REPS_W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = WIDTH'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; m_ready = 1'b1;
        repeat (LATENCY) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_read_setup: m_valid=%b busy=%b want 1 1", m_valid, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_abort: m_valid=%b busy=%b done=%b want 0 0 0", m_valid, busy, done);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL reset_no_done: done=%b busy=%b want 0 0", done, busy);
            end
        end
    endtask

    task automatic test_ignore;
        @(posedge clk); #1;
        start = 1'b1; cfg_len = '0; cfg_reps = REPS_W'(2);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0) begin
                errors++; $display("FAIL len0_ignored: busy=%b done=%b s_ready=%b want 0 0 0", busy, done, s_ready);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < DEPTH; i++) wdata[i] = WIDTH'($urandom);
        run_job(5, 1, 0, 0, 1'b1, "start_busy");
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) wdata[i] = WIDTH'($urandom);
        run_job(DEPTH, 1, 0, 0, 1'b0, "full_depth");
    endtask

    task automatic test_back_to_back;
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < DEPTH; i++) wdata[i] = WIDTH'($urandom);
            run_job(int'($urandom_range(1, DEPTH)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, "b2b");
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_one_cycle: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reps();
        test_backpressure();
        test_gapped_write();
        test_reset_mid();
        test_basic();
        test_ignore();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
